// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO widths, burst limit and write-arbiter state encoding
package fifo_pkg;
    localparam int D_WIDTH_DEF   = 4;
    localparam int A_WIDTH_DEF   = 4;
    localparam int MAX_BURST_DEF = 4;
    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} arb_state_e;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating-priority search for the first request after last
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic         valid,
    output logic [W-1:0] idx
);
    always_comb begin
        valid = |req;
        idx   = last;
        for (int k = N; k >= 1; k--)
            if (req[(int'(last) + k) % N]) idx = W'((int'(last) + k) % N);
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-limited sharing of the FIFO write port
import fifo_pkg::*;
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int D_WIDTH   = D_WIDTH_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int OW        = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*D_WIDTH-1:0]   wdata_in,
    input  logic                       full,
    output logic [N_REQ-1:0]           ack,
    output logic                       fifo_winc,
    output logic [D_WIDTH-1:0]         fifo_wdata,
    output logic [OW-1:0]              owner,
    output logic                       busy
);
    arb_state_e    state_q, state_d;
    logic [OW-1:0] owner_q, owner_d, pick_idx;
    logic [3:0]    cnt_q, cnt_d;
    logic          pick_valid, accept;

    rr_pick #(.N(N_REQ), .W(OW)) u_pick (
        .req(req), .last(owner_q), .valid(pick_valid), .idx(pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        ack        = '0;
        fifo_winc  = 1'b0;
        fifo_wdata = '0;
        accept     = (state_q == BURST) && req[owner_q] && !full;
        if (state_q == IDLE) begin
            if (pick_valid) begin
                owner_d = pick_idx;
                cnt_d   = '0;
                state_d = BURST;
            end
        end else begin
            fifo_wdata     = wdata_in[owner_q*D_WIDTH +: D_WIDTH];
            ack[owner_q]   = accept && rst_n;
            fifo_winc      = accept && rst_n;
            if (!req[owner_q]) state_d = IDLE;
            else if (accept) begin
                if (cnt_q == 4'(MAX_BURST - 1)) state_d = IDLE;
                else cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= OW'(N_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    assign owner = owner_q;
    assign busy  = (state_q == BURST) && rst_n;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: random producers checked against a behavioural round-robin model
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int D  = 4;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*D-1:0] wdata_in;
    logic           full;
    logic [N-1:0]   ack;
    logic           fifo_winc;
    logic [D-1:0]   fifo_wdata;
    logic [1:0]     owner;
    logic           busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_writes = 0;
    int ack_cnt[N];
    int pend[N];
    logic [D-1:0] data[N];

    bit m_busy;
    int m_owner;
    int m_done;

    fifo_wr_arbiter #(.N_REQ(N), .D_WIDTH(D), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wdata_in(wdata_in), .full(full),
        .ack(ack), .fifo_winc(fifo_winc), .fifo_wdata(fifo_wdata),
        .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic [N-1:0] rq, input logic f);
        bit acc;
        logic [N-1:0] e_ack;
        @(negedge clk);
        rst_n = r;
        req   = rq;
        full  = f;
        for (int i = 0; i < N; i++) wdata_in[i*D +: D] = data[i];
        #1;
        acc   = m_busy && rq[m_owner] && !f && r;
        e_ack = acc ? N'(1 << m_owner) : '0;
        check("ack", 32'(ack), 32'(e_ack));
        check("winc", 32'(fifo_winc), 32'(acc));
        check("busy", 32'(busy), 32'(m_busy && r));
        check("owner", 32'(owner), 32'(m_owner));
        check("wdata", 32'(fifo_wdata), m_busy ? 32'(data[m_owner]) : 32'd0);
        check("ovf", 32'(fifo_winc & full), 32'd0);
        for (int i = 0; i < N; i++) if (ack[i]) ack_cnt[i]++;
        @(posedge clk);
        if (!r) begin
            m_busy  = 0;
            m_owner = N - 1;
            m_done  = 0;
        end else if (!m_busy) begin
            for (int k = 1; k <= N; k++)
                if (rq[(m_owner + k) % N]) begin
                    m_owner = (m_owner + k) % N;
                    m_busy  = 1;
                    m_done  = 0;
                    break;
                end
        end else if (!rq[m_owner]) m_busy = 0;
        else if (acc) begin
            m_done++;
            if (m_done == MB) m_busy = 0;
        end
        if (acc) begin
            n_writes++;
            for (int i = 0; i < N; i++) if (e_ack[i]) begin
                data[i] = D'($urandom);
                if (pend[i] > 0) pend[i]--;
            end
        end
    endtask

    initial begin
        logic [N-1:0] rq;
        m_busy = 0; m_owner = N - 1; m_done = 0;
        for (int i = 0; i < N; i++) begin
            data[i] = D'(i + 1);
            pend[i] = 0;
            ack_cnt[i] = 0;
        end
        rst_n = 1'b0; req = '0; full = 1'b0; wdata_in = '0;
        step(1'b0, 4'b1111, 1'b0);
        step(1'b0, 4'b1111, 1'b0);
        step(1'b1, 4'b1111, 1'b0);
        #1;
        check("first_owner", 32'(owner), 32'd0);
        check("first_busy", 32'(busy), 32'd1);
        for (int i = 0; i < N; i++) ack_cnt[i] = 0;
        for (int c = 0; c < 20; c++) step(1'b1, 4'b1111, 1'b0);
        for (int i = 0; i < N; i++) check($sformatf("fair_acks%0d", i), 32'(ack_cnt[i]), 32'(MB));
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if (pend[i] == 0 && $urandom_range(0, 3) == 0) pend[i] = $urandom_range(1, 8);
            for (int i = 0; i < N; i++)
                rq[i] = (pend[i] > 0) && ($urandom_range(0, 15) != 0);
            step($urandom_range(0, 199) != 0, rq, $urandom_range(0, 3) == 0);
        end
        check("writes_seen", 32'(n_writes > 500), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter that shares the 4-bit async FIFO write interface among N_REQ producers. It runs entirely in the FIFO write clock domain and consumes the FIFO `full` flag. It drives the FIFO write enable and data, granting each owner a bounded burst so no producer can monopolise the buffer.

Parameters:
N_REQ, 4, number of requesters (2..8)
D_WIDTH, 4, data word width, equal to the FIFO data width
MAX_BURST, 4, maximum accepted writes per grant (1..15)

Ports:
clk  input  1  write-domain clock; all logic on its rising edge
rst_n  input  1  reset, synchronous, active-low
req  input  N_REQ  per-requester write request; level, held until ack
wdata_in  input  N_REQ*D_WIDTH  packed requester data; slice i = bits [i*D_WIDTH +: D_WIDTH]
full  input  1  FIFO full flag, synchronous to clk
ack  output  N_REQ  one-hot; ack[i]=1 means slice i is written this cycle
fifo_winc  output  1  FIFO write enable
fifo_wdata  output  D_WIDTH  FIFO write data
owner  output  $clog2(N_REQ)  index of the current or last grantee
busy  output  1  high while in BURST

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is synchronous and active-low.
- Registered state: `state` {IDLE, BURST}, `owner`, `cnt` (burst count, 4 bits).
- Reset (sampled low at an edge):
  - state=IDLE, cnt=0, owner=N_REQ-1, so requester 0 has top priority next.
- While rst_n is low, ack, fifo_winc and busy are combinationally forced to 0, including mid-burst.
- Outputs after reset: ack=0, fifo_winc=0, fifo_wdata=0, busy=0.
- IDLE:
  - If any req bit is set, pick the first set bit scanning owner+1, owner+2, … modulo N_REQ.
  - Load it into owner, set cnt=0, go to BURST.
  - If no req bit is set, stay in IDLE; owner is unchanged.
- BURST:
  - accept = req[owner] & ~full.
  - ack[owner] = fifo_winc = accept; fifo_wdata = slice owner whenever in BURST, else 0.
  - Combinational path: req/full to ack/winc.
- BURST transitions, in priority order:
  - If req[owner]=0: go to IDLE. No write occurs.
  - Else if accept=1 and cnt==MAX_BURST-1: go to IDLE.
  - Else if accept=1: cnt increments.
  - Else (full=1): hold. cnt, owner and state are frozen and there is no timeout.
- Latency: req rising before edge T gives BURST from T and the earliest ack in cycle T+1.
- Re-arbitration costs exactly one IDLE cycle between grants, including re-grant of the same requester.
- Fairness: after any grant ends, every other pending requester is served before the same owner again.
- Requester contract: it drops req only after the ack cycle of its last word. Dropping req without ack is legal; that word is not written.
- Overflow: fifo_winc is never 1 while full is 1.

Decomposition:
- Shared package fifo_pkg holds:
  - D_WIDTH and A_WIDTH defaults.
  - Arbiter state encoding: IDLE=1'b0, BURST=1'b1.
  - MAX_BURST default.
- One combinational sub-module, rr_pick (inputs req, last; outputs valid, idx): rotating priority search. It is reused by future read-side schedulers.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with req=4'b1111 -> ack=0, fifo_winc=0, busy=0; first grant after release is owner=0.
2. Long burst: req[1] held with data 1..6, full=0 -> ack[1] on 4 consecutive cycles with wdata 1,2,3,4; one IDLE cycle (busy=0); then 2 more acks with 5,6.
3. Fairness: req=4'b1111 held continuously -> owners in order 0,1,2,3,0, 4 writes each, one idle cycle between grants.
4. Full stall: full=1 for 3 cycles after the 2nd write of owner 2 -> fifo_winc=0 for those cycles, owner=2 and cnt=2 held; writes 3 and 4 follow, then IDLE.
5. Early release: owner 0 drops req after its 1st ack while req[3]=1 -> IDLE next cycle, then owner=3, no extra write from 0.
6. Mid-burst reset: rst_n=0 during owner 2's 2nd write cycle -> fifo_winc=0 that same cycle; IDLE; after release with req=4'b0110, owner=1 is granted first.
